// File: rtl/uart_rx_controller.sv
// UART receive front end: 2-flop line synchroniser, start detect, mid-bit sampling and SIPO drive.
// Optional parity check is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_controller #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 sample_tick,
  input  logic                 rxd,
  output logic                 sipo_bit,
  output logic                 sipo_read,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 ferror,
  output logic                 perror
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_controller: unsupported parameter set");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rxd_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   sipo_bit_d, sipo_read_d, data_valid_d, ferror_d;
  logic [DATA_BITS-1:0]   rx_data_d;
  logic                   par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  logic perror_d;
  assign par_bad = par_err_q;
`else
  assign par_bad = 1'b0;
  assign perror  = 1'b0;
`endif

  assign rxd_s = sync_q[1];

  // State, counters, synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      sipo_bit   <= 1'b0;
      sipo_read  <= 1'b0;
      data_valid <= 1'b0;
      rx_data    <= '0;
      ferror     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
      perror     <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[0], rxd};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      sipo_bit   <= sipo_bit_d;
      sipo_read  <= sipo_read_d;
      data_valid <= data_valid_d;
      rx_data    <= rx_data_d;
      ferror     <= ferror_d;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
      perror     <= perror_d;
`endif
    end
  end

  // Next-state and output decode; every decision is qualified by sample_tick
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    sipo_bit_d   = sipo_bit;
    sipo_read_d  = 1'b0;
    data_valid_d = 1'b0;
    rx_data_d    = rx_data;
    ferror_d     = ferror;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
    perror_d     = perror;
`endif

    if (!rx_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (sample_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end

        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            if (!rxd_s) begin
              // Confirmed start bit: a new frame begins, so old errors are retired
              state_d  = ST_DATA;
              idx_d    = '0;
              ferror_d = 1'b0;
`ifdef UART_RX_PARITY_EN
              par_err_d = 1'b0;
              perror_d  = 1'b0;
`endif
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            shreg_d     = {rxd_s, shreg_q[DATA_BITS-1:1]};
            sipo_bit_d  = rxd_s;
            sipo_read_d = 1'b1;
            cnt_d       = '0;
            idx_d       = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == BIT_LAST) begin
            par_err_d = rxd_s ^ (^shreg_q) ^ 1'(PARITY_ODD);
            state_d   = ST_STOP;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif

        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            // Return to IDLE at the stop midpoint so a following start edge is not missed
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (rxd_s && !par_bad) begin
              data_valid_d = 1'b1;
              rx_data_d    = shreg_q;
              ferror_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
              perror_d     = 1'b0;
`endif
            end else begin
              if (!rxd_s) ferror_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              if (par_bad) perror_d = 1'b1;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed self-checking bench for uart_rx_controller (OVERSAMPLE=16, DATA_BITS=8, tick every 4th clk).
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_controller;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       reset;
  logic       rx_en;
  logic       sample_tick;
  logic       rxd;
  logic       sipo_bit;
  logic       sipo_read;
  logic       data_valid;
  logic [7:0] rx_data;
  logic       ferror;
  logic       perror;

  int n_tests = 0;
  int n_fail  = 0;
  int n_read  = 0;
  int n_valid = 0;
  int n_both  = 0;
  logic bit_log[$];

  uart_rx_controller #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_ODD(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .sample_tick (sample_tick),
    .rxd         (rxd),
    .sipo_bit    (sipo_bit),
    .sipo_read   (sipo_read),
    .data_valid  (data_valid),
    .rx_data     (rx_data),
    .ferror      (ferror),
    .perror      (perror)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clock tick on every 4th clock, driven away from the active edge
  initial begin
    logic [1:0] tdiv;
    tdiv = 2'd0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = tdiv + 2'd1;
      sample_tick = (tdiv == 2'd0);
    end
  end

  // Output monitor: records every strobe cycle and the bit presented with it
  initial begin
    forever begin
      @(negedge clk);
      if (sipo_read === 1'b1) begin
        bit_log.push_back(sipo_bit);
        n_read++;
      end
      if (data_valid === 1'b1) n_valid++;
      if (sipo_read === 1'b1 && data_valid === 1'b1) n_both++;
    end
  end

  function automatic logic [7:0] get_byte(input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (base + i < bit_log.size()) r[i] = bit_log[base + i];
      else r[i] = 1'bx;
    end
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({sipo_bit, sipo_read, data_valid, ferror, perror} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset.flags: got %b want 00000", {sipo_bit, sipo_read, data_valid, ferror, perror});
    end
    n_tests++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset.rx_data: got %h want 00", rx_data);
    end
  endtask

  task automatic test_good_frame();
    int br, bv;
    br = n_read; bv = n_valid;
    send_frame(8'hA5, 1'b1);
    idle(32);
    n_tests++;
    if (n_read - br !== 8) begin n_fail++; $display("FAIL good.reads: got %0d want 8", n_read - br); end
    n_tests++;
    if (get_byte(br) !== 8'hA5) begin n_fail++; $display("FAIL good.sipo_bits: got %h want a5", get_byte(br)); end
    n_tests++;
    if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL good.rx_data: got %h want a5", rx_data); end
    n_tests++;
    if (n_valid - bv !== 1) begin n_fail++; $display("FAIL good.valids: got %0d want 1", n_valid - bv); end
    n_tests++;
    if ({ferror, perror} !== 2'b00) begin n_fail++; $display("FAIL good.errors: got %b want 00", {ferror, perror}); end
    n_tests++;
    if (sipo_bit !== 1'b1) begin n_fail++; $display("FAIL good.sipo_bit_hold: got %b want 1", sipo_bit); end
  endtask

  task automatic test_framing_error();
    int br, bv;
    br = n_read; bv = n_valid;
    send_frame(8'h3C, 1'b0);
    idle(64);
    n_tests++;
    if (n_read - br !== 8) begin n_fail++; $display("FAIL ferr.reads: got %0d want 8", n_read - br); end
    n_tests++;
    if (get_byte(br) !== 8'h3C) begin n_fail++; $display("FAIL ferr.sipo_bits: got %h want 3c", get_byte(br)); end
    n_tests++;
    if (ferror !== 1'b1) begin n_fail++; $display("FAIL ferr.ferror: got %b want 1", ferror); end
    n_tests++;
    if (n_valid - bv !== 0) begin n_fail++; $display("FAIL ferr.valids: got %0d want 0", n_valid - bv); end
    n_tests++;
    if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL ferr.rx_data_hold: got %h want a5", rx_data); end
    n_tests++;
    if (sipo_bit !== 1'b0) begin n_fail++; $display("FAIL ferr.sipo_bit_hold: got %b want 0", sipo_bit); end
  endtask

  task automatic test_false_start();
    int br, bv;
    idle(16);
    br = n_read; bv = n_valid;
    rxd = 1'b0;
    idle(16);
    rxd = 1'b1;
    idle(100);
    n_tests++;
    if (n_read - br !== 0) begin n_fail++; $display("FAIL false_start.reads: got %0d want 0", n_read - br); end
    n_tests++;
    if (n_valid - bv !== 0) begin n_fail++; $display("FAIL false_start.valids: got %0d want 0", n_valid - bv); end
    n_tests++;
    if ({ferror, perror} !== 2'b10) begin n_fail++; $display("FAIL false_start.errors: got %b want 10", {ferror, perror}); end
    n_tests++;
    if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL false_start.rx_data: got %h want a5", rx_data); end
  endtask

  task automatic test_back_to_back();
    int br, bv, bb;
    logic [7:0] d;
    br = n_read; bv = n_valid; bb = n_both;
    d = 8'h12;
    drive_bit(1'b0);
    drive_bit(d[0]);
    n_tests++;
    if (ferror !== 1'b0) begin n_fail++; $display("FAIL b2b.ferror_clear: got %b want 0", ferror); end
    for (int i = 1; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(1'b1);
    send_frame(8'h34, 1'b1);
    idle(32);
    n_tests++;
    if (n_read - br !== 16) begin n_fail++; $display("FAIL b2b.reads: got %0d want 16", n_read - br); end
    n_tests++;
    if (get_byte(br) !== 8'h12) begin n_fail++; $display("FAIL b2b.bits0: got %h want 12", get_byte(br)); end
    n_tests++;
    if (get_byte(br + 8) !== 8'h34) begin n_fail++; $display("FAIL b2b.bits1: got %h want 34", get_byte(br + 8)); end
    n_tests++;
    if (n_valid - bv !== 2) begin n_fail++; $display("FAIL b2b.valids: got %0d want 2", n_valid - bv); end
    n_tests++;
    if (n_both - bb !== 0) begin n_fail++; $display("FAIL b2b.overlap: got %0d want 0", n_both - bb); end
    n_tests++;
    if (rx_data !== 8'h34) begin n_fail++; $display("FAIL b2b.rx_data: got %h want 34", rx_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int bv;
    logic [7:0] d;
    d = 8'h07;
    bv = n_valid;
    send_frame(d, 1'b1);
    idle(32);
    n_tests++;
    if (n_valid - bv !== 1) begin n_fail++; $display("FAIL par_ok.valids: got %0d want 1", n_valid - bv); end
    n_tests++;
    if ({rx_data, perror} !== {8'h07, 1'b0}) begin n_fail++; $display("FAIL par_ok.data_perr: got %h/%b want 07/0", rx_data, perror); end
    bv = n_valid;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b0);
    drive_bit(1'b1);
    idle(32);
    n_tests++;
    if (n_valid - bv !== 0) begin n_fail++; $display("FAIL par_bad.valids: got %0d want 0", n_valid - bv); end
    n_tests++;
    if ({perror, ferror} !== 2'b10) begin n_fail++; $display("FAIL par_bad.errors: got %b want 10", {perror, ferror}); end
    n_tests++;
    if (rx_data !== 8'h07) begin n_fail++; $display("FAIL par_bad.rx_data: got %h want 07", rx_data); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int br, bv;
    bit hit;
    br = n_read; bv = n_valid;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rxd = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2 * BIT_CLKS && !hit; i++) begin
      @(negedge clk);
      if (n_read - br >= 3) hit = 1'b1;
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL rst_mid.third_strobe: got %0d strobes want 3 (timeout)", n_read - br); end
    reset = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({sipo_bit, sipo_read, data_valid, ferror, perror, rx_data} !== 13'b0) begin
      n_fail++;
      $display("FAIL rst_mid.outputs: got %b want 0", {sipo_bit, sipo_read, data_valid, ferror, perror, rx_data});
    end
    @(negedge clk);
    reset = 1'b1;
    idle(128);
    n_tests++;
    if (n_read - br !== 3 || n_valid - bv !== 0) begin
      n_fail++;
      $display("FAIL rst_mid.no_more: got reads %0d valids %0d want 3 0", n_read - br, n_valid - bv);
    end
    br = n_read; bv = n_valid;
    send_frame(8'h5A, 1'b1);
    idle(32);
    n_tests++;
    if (rx_data !== 8'h5A || n_valid - bv !== 1) begin
      n_fail++;
      $display("FAIL rst_mid.recover: got %h/%0d want 5a/1", rx_data, n_valid - bv);
    end
    n_tests++;
    if (get_byte(br) !== 8'h5A) begin n_fail++; $display("FAIL rst_mid.bits: got %h want 5a", get_byte(br)); end
  endtask

  task automatic test_rx_en_abort();
    int br, bv;
    logic [7:0] d;
    d = 8'h96;
    br = n_read; bv = n_valid;
    drive_bit(1'b0);
    drive_bit(d[0]);
    drive_bit(d[1]);
    rx_en = 1'b0;
    for (int i = 2; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(1'b1);
    idle(64);
    n_tests++;
    if (n_read - br !== 2) begin n_fail++; $display("FAIL en_abort.reads: got %0d want 2", n_read - br); end
    n_tests++;
    if (n_valid - bv !== 0) begin n_fail++; $display("FAIL en_abort.valids: got %0d want 0", n_valid - bv); end
    n_tests++;
    if ({rx_data, ferror} !== {8'h5A, 1'b0}) begin n_fail++; $display("FAIL en_abort.hold: got %h/%b want 5a/0", rx_data, ferror); end
    rx_en = 1'b1;
    idle(16);
    br = n_read; bv = n_valid;
    send_frame(8'hFF, 1'b1);
    idle(32);
    n_tests++;
    if (rx_data !== 8'hFF || n_valid - bv !== 1) begin
      n_fail++;
      $display("FAIL en_resume.rx_data: got %h/%0d want ff/1", rx_data, n_valid - bv);
    end
    n_tests++;
    if (n_read - br !== 8) begin n_fail++; $display("FAIL en_resume.reads: got %0d want 8", n_read - br); end
  endtask

  initial begin
    reset = 1'b0;
    rx_en = 1'b1;
    rxd   = 1'b1;
    idle(3);
    test_reset();
    reset = 1'b1;
    idle(8);
    test_good_frame();
    test_framing_error();
    test_false_start();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    test_rx_en_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
